wb_write_arbiter: RTL and testbench

- Single-port register-file writer: merges ALU writeback and long-latency load returns into one write per cycle.
- Drives the register file's write_reg / write_data / regWrite inputs through registered outputs.
- Buffers load returns in a small FIFO and exports a busy mask so the hazard logic can protect pending load destinations.
- Sits in the WB stage between the ALU/MEM result paths and the register file.

---
 rtl/mips_pkg.sv | 15 +
 rtl/wb_write_arbiter_if.sv | 33 +++
 rtl/wb_load_fifo.sv | 79 +++++++
 rtl/wb_write_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared writeback-path types and widths.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Writeback bus: ALU result, load return and register-file write port.
interface wb_write_arbiter_if;
  import mips_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_stall;

  logic                  load_valid;
  logic [REG_ADDR_W-1:0] load_dest;
  logic [DATA_W-1:0]     load_data;
  logic                  load_ready;

  logic [REG_ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0]     rf_write_data;
  logic                  rf_reg_write;

  logic [31:0]           busy_mask;

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_dest, alu_data, load_valid, load_dest, load_data,
    output alu_stall, load_ready, rf_write_reg, rf_write_data, rf_reg_write, busy_mask
  );

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_dest, alu_data, load_valid, load_dest, load_data,
    input  alu_stall, load_ready, rf_write_reg, rf_write_data, rf_reg_write, busy_mask
  );

endinterface

// File: rtl/wb_load_fifo.sv
// Load-return queue; exposes per-slot valid/dest so the owner can build a busy mask.
module wb_load_fifo
  import mips_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [$clog2(LQ_DEPTH+1)-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic [LQ_DEPTH-1:0]   entry_valid,
  output logic [REG_ADDR_W-1:0] entry_dest [LQ_DEPTH]
);

  localparam int unsigned PtrW = $clog2(LQ_DEPTH);
  localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);

  wb_req_t             mem_q [LQ_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [LQ_DEPTH-1:0] valid_q, valid_d;
  logic                do_push, do_pop;

  assign full    = (count_q == CntW'(LQ_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // Push into a full queue is allowed only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign head        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign entry_valid = valid_q;

  // Per-slot destination view for busy-mask generation.
  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) begin
      entry_dest[i] = mem_q[i].dest;
    end
  end

  // Next occupancy count and slot-valid bits; a same-slot pop+push leaves the slot valid.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    valid_d = valid_q;
    if (do_pop)  valid_d[rd_ptr_q] = 1'b0;
    if (do_push) valid_d[wr_ptr_q] = 1'b1;
  end

  // Pointer, count and valid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage; contents are don't-care until the slot is marked valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_req;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// WB-stage arbiter: one register-file write per cycle from ALU results or load returns.
module wb_write_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned LQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  wb_write_arbiter_if.slave bus
);

  localparam int unsigned CntW    = $clog2(LQ_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [CntW-1:0]    LqCap     = CntW'(LQ_DEPTH);

  logic                  lq_push, lq_pop, lq_full, lq_empty;
  wb_req_t               lq_push_req, lq_head;
  logic [CntW-1:0]       lq_count;
  logic [LQ_DEPTH-1:0]   lq_entry_valid;
  logic [REG_ADDR_W-1:0] lq_entry_dest [LQ_DEPTH];

  logic [31:0]           busy_mask;
  logic [StarveW-1:0]    starve_q, starve_d;
  logic                  starve_hit;
  logic                  alu_live, alu_stall, alu_win;
  logic                  load_live, load_ready, bypass;
  logic                  wr_en;
  wb_req_t               wr_req;

  logic                  rf_reg_write_q;
  logic [REG_ADDR_W-1:0] rf_write_reg_q;
  logic [DATA_W-1:0]     rf_write_data_q;

  // Occupancy is read through count; full is redundant here.
  logic                  unused_lq_full;
  assign unused_lq_full = lq_full;

  wb_load_fifo #(
    .LQ_DEPTH(LQ_DEPTH)
  ) u_load_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (lq_push),
    .push_req    (lq_push_req),
    .pop         (lq_pop),
    .head        (lq_head),
    .count       (lq_count),
    .full        (lq_full),
    .empty       (lq_empty),
    .entry_valid (lq_entry_valid),
    .entry_dest  (lq_entry_dest)
  );

  // Registers targeted by queued loads; r0 never counts as busy.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_entry_valid[i]) busy_mask[lq_entry_dest[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  assign alu_live   = bus.alu_valid && (bus.alu_dest != ZERO_REG);
  assign load_live  = bus.load_valid && (bus.load_dest != ZERO_REG);
  assign starve_hit = (starve_q >= StarveMax);
  assign load_ready = (lq_count < LqCap);

  // Stall on starvation or on WAW against an older queued load.
  assign alu_stall  = alu_live && (starve_hit || busy_mask[bus.alu_dest]);
  assign alu_win    = alu_live && !alu_stall;
  assign lq_pop     = !alu_win && !lq_empty;
  assign bypass     = !alu_win && lq_empty && load_live;
  assign lq_push    = load_live && load_ready && !bypass;
  assign wr_en      = alu_win || lq_pop || bypass;

  assign lq_push_req = '{dest: bus.load_dest, data: bus.load_data};

  // Write-source mux in priority order ALU, queue head, bypassed load.
  always_comb begin
    wr_req = '{dest: bus.load_dest, data: bus.load_data};
    if (alu_win) begin
      wr_req = '{dest: bus.alu_dest, data: bus.alu_data};
    end else if (lq_pop) begin
      wr_req = lq_head;
    end
  end

  // Starvation counter: counts cycles the queue head is held back, saturating.
  always_comb begin
    starve_d = starve_q;
    if (lq_empty || lq_pop) begin
      starve_d = '0;
    end else if (!starve_hit) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  // Registered write port and starvation state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write_q  <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      starve_q        <= '0;
    end else begin
      rf_reg_write_q <= wr_en;
      if (wr_en) begin
        rf_write_reg_q  <= wr_req.dest;
        rf_write_data_q <= wr_req.data;
      end
      starve_q <= starve_d;
    end
  end

  assign bus.alu_stall     = alu_stall;
  assign bus.load_ready    = load_ready;
  assign bus.busy_mask     = busy_mask;
  assign bus.rf_reg_write  = rf_reg_write_q;
  assign bus.rf_write_reg  = rf_write_reg_q;
  assign bus.rf_write_data = rf_write_data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_wb_write_arbiter;
  import mips_pkg::*;

  localparam int unsigned LqDepth     = 2;
  localparam int unsigned StarveLimit = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_write_arbiter_if bus ();

  wb_write_arbiter #(
    .LQ_DEPTH    (LqDepth),
    .STARVE_LIMIT(StarveLimit)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus for the next cycle.
  logic        in_av, in_lv;
  logic [4:0]  in_ad, in_ld;
  logic [31:0] in_adata, in_ldata;

  // Reference model: queued loads in arrival order plus blocked-cycle count.
  wb_req_t     lq[$];
  int          starve;
  logic        exp_stall, exp_ready, exp_we;
  logic [31:0] exp_busy, exp_data;
  logic [4:0]  exp_reg;

  // Observed values.
  logic        act_stall, act_ready, act_we;
  logic [31:0] act_busy, act_data;
  logic [4:0]  act_reg;

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    foreach (lq[i]) m[lq[i].dest] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    lq.delete();
    starve   = 0;
    exp_we   = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
  endtask

  task automatic set_idle();
    in_av = 1'b0; in_ad = '0; in_adata = '0;
    in_lv = 1'b0; in_ld = '0; in_ldata = '0;
  endtask

  // Apply inputs, sample combinational outputs, clock once, sample the write port,
  // and advance the model. Entered and left 1ns after a rising edge.
  task automatic tick();
    logic        nwe, popped, bypassed;
    logic [4:0]  nreg;
    logic [31:0] ndata;
    int          size0;
    bus.alu_valid  = in_av;  bus.alu_dest  = in_ad; bus.alu_data  = in_adata;
    bus.load_valid = in_lv;  bus.load_dest = in_ld; bus.load_data = in_ldata;
    #2;
    exp_busy  = model_busy();
    exp_ready = (lq.size() < LqDepth);
    exp_stall = in_av && (in_ad != 0) && ((starve >= StarveLimit) || exp_busy[in_ad]);
    act_stall = bus.alu_stall;
    act_ready = bus.load_ready;
    act_busy  = bus.busy_mask;
    size0 = lq.size();
    nwe = 1'b0; nreg = '0; ndata = '0; popped = 1'b0; bypassed = 1'b0;
    if (in_av && in_ad != 0 && !exp_stall) begin
      nwe = 1'b1; nreg = in_ad; ndata = in_adata;
    end else if (size0 > 0) begin
      nwe = 1'b1; nreg = lq[0].dest; ndata = lq[0].data;
      void'(lq.pop_front());
      popped = 1'b1;
    end else if (in_lv && in_ld != 0) begin
      nwe = 1'b1; nreg = in_ld; ndata = in_ldata; bypassed = 1'b1;
    end
    if (in_lv && exp_ready && in_ld != 0 && !bypassed) lq.push_back('{dest: in_ld, data: in_ldata});
    if (size0 == 0 || popped) starve = 0;
    else if (starve < StarveLimit) starve++;
    @(posedge clk);
    #1;
    act_we   = bus.rf_reg_write;
    act_reg  = bus.rf_write_reg;
    act_data = bus.rf_write_data;
    exp_we = nwe;
    if (nwe) begin
      exp_reg = nreg; exp_data = ndata;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.rf_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.rf_reg_write); end
    checks++;
    if (bus.rf_write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg got %0d want 0", bus.rf_write_reg); end
    checks++;
    if (bus.rf_write_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.rf_write_data); end
    checks++;
    if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", bus.busy_mask); end
    checks++;
    if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.alu_stall); end
    checks++;
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.load_ready); end
  endtask

  task automatic test_alu_only();
    set_idle();
    in_av = 1'b1; in_ad = 5'd5; in_adata = 32'hDEADBEEF;
    tick();
    checks++;
    if (act_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", act_stall); end
    checks++;
    if (act_we !== 1'b1 || act_reg !== 5'd5 || act_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write got we=%b r%0d=%h want we=1 r5=deadbeef", act_we, act_reg, act_data);
    end
    in_ad = 5'd0; in_adata = 32'h12345678;
    tick();
    checks++;
    if (act_we !== 1'b0 || act_stall !== 1'b0) begin
      errors++; $display("FAIL alu_r0 got we=%b stall=%b want 0 0", act_we, act_stall);
    end
    set_idle();
    tick();
  endtask

  task automatic test_bypass();
    set_idle();
    in_lv = 1'b1; in_ld = 5'd8; in_ldata = 32'h1234;
    tick();
    checks++;
    if (act_busy !== 32'd0 || act_ready !== 1'b1) begin
      errors++; $display("FAIL bypass_comb got busy=%h ready=%b want 0 1", act_busy, act_ready);
    end
    checks++;
    if (act_we !== 1'b1 || act_reg !== 5'd8 || act_data !== 32'h1234) begin
      errors++; $display("FAIL bypass_write got we=%b r%0d=%h want we=1 r8=1234", act_we, act_reg, act_data);
    end
    set_idle();
    tick();
    checks++;
    if (act_busy !== 32'd0 || act_we !== 1'b0) begin
      errors++; $display("FAIL bypass_after got busy=%h we=%b want 0 0", act_busy, act_we);
    end
  endtask

  task automatic test_collision();
    set_idle();
    in_av = 1'b1; in_ad = 5'd3; in_adata = 32'hAAAA0003;
    in_lv = 1'b1; in_ld = 5'd9; in_ldata = 32'hBBBB0009;
    tick();
    checks++;
    if (act_ready !== 1'b1 || act_stall !== 1'b0) begin
      errors++; $display("FAIL coll_comb got ready=%b stall=%b want 1 0", act_ready, act_stall);
    end
    checks++;
    if (act_we !== 1'b1 || act_reg !== 5'd3 || act_data !== 32'hAAAA0003) begin
      errors++; $display("FAIL coll_first got we=%b r%0d=%h want r3=aaaa0003", act_we, act_reg, act_data);
    end
    set_idle();
    tick();
    checks++;
    if (act_busy !== (32'd1 << 9) || act_ready !== 1'b1) begin
      errors++; $display("FAIL coll_busy got busy=%h ready=%b want 00000200 1", act_busy, act_ready);
    end
    checks++;
    if (act_we !== 1'b1 || act_reg !== 5'd9 || act_data !== 32'hBBBB0009) begin
      errors++; $display("FAIL coll_second got we=%b r%0d=%h want r9=bbbb0009", act_we, act_reg, act_data);
    end
    tick();
    checks++;
    if (act_busy !== 32'd0 || act_we !== 1'b0) begin
      errors++; $display("FAIL coll_after got busy=%h we=%b want 0 0", act_busy, act_we);
    end
  endtask

  task automatic test_fill();
    logic [31:0] held;
    set_idle();
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c <= 6) begin
        in_av = 1'b1; in_ad = 5'd1;
        in_adata = (c == 6) ? held : 32'h100 + c;
        held = in_adata;
      end
      if (c == 0) begin in_lv = 1'b1; in_ld = 5'd10; in_ldata = 32'hD10; end
      if (c == 1) begin in_lv = 1'b1; in_ld = 5'd11; in_ldata = 32'hD11; end
      tick();
      checks++;
      if (act_stall !== (c == 5)) begin
        errors++; $display("FAIL fill_stall c%0d got %b want %b", c, act_stall, (c == 5));
      end
      if (c == 2) begin
        checks++;
        if (act_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", act_ready); end
      end
      if (c == 5) begin
        checks++;
        if (act_we !== 1'b1 || act_reg !== 5'd10 || act_data !== 32'hD10) begin
          errors++; $display("FAIL fill_pop got we=%b r%0d=%h want r10=d10", act_we, act_reg, act_data);
        end
      end
      if (c == 6) begin
        checks++;
        if (act_we !== 1'b1 || act_reg !== 5'd1 || act_data !== 32'h105) begin
          errors++; $display("FAIL fill_alu got we=%b r%0d=%h want r1=105", act_we, act_reg, act_data);
        end
      end
      if (c == 7) begin
        checks++;
        if (act_busy !== (32'd1 << 11) || act_we !== 1'b1 || act_reg !== 5'd11 || act_data !== 32'hD11) begin
          errors++;
          $display("FAIL fill_drain got busy=%h we=%b r%0d=%h want busy=00000800 r11=d11",
                   act_busy, act_we, act_reg, act_data);
        end
      end
    end
    set_idle();
    tick();
  endtask

  task automatic test_waw();
    set_idle();
    in_av = 1'b1; in_ad = 5'd2; in_adata = 32'h22;
    in_lv = 1'b1; in_ld = 5'd7; in_ldata = 32'h1007;
    tick();
    set_idle();
    in_av = 1'b1; in_ad = 5'd7; in_adata = 32'hA007;
    tick();
    checks++;
    if (act_stall !== 1'b1 || act_busy[7] !== 1'b1) begin
      errors++; $display("FAIL waw_stall got stall=%b busy7=%b want 1 1", act_stall, act_busy[7]);
    end
    checks++;
    if (act_we !== 1'b1 || act_reg !== 5'd7 || act_data !== 32'h1007) begin
      errors++; $display("FAIL waw_load got we=%b r%0d=%h want r7=1007", act_we, act_reg, act_data);
    end
    tick();
    checks++;
    if (act_stall !== 1'b0 || act_we !== 1'b1 || act_reg !== 5'd7 || act_data !== 32'hA007) begin
      errors++;
      $display("FAIL waw_alu got stall=%b we=%b r%0d=%h want 0 1 r7=a007", act_stall, act_we, act_reg, act_data);
    end
    set_idle();
    tick();
  endtask

  task automatic test_async_reset();
    set_idle();
    in_av = 1'b1; in_ad = 5'd1; in_adata = 32'h11;
    in_lv = 1'b1; in_ld = 5'd20; in_ldata = 32'h20;
    tick();
    in_adata = 32'h12; in_ld = 5'd21; in_ldata = 32'h21;
    tick();
    checks++;
    if (act_we !== 1'b1) begin errors++; $display("FAIL arst_pre_we got %b want 1", act_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rf_reg_write !== 1'b0 || bus.rf_write_reg !== 5'd0 || bus.rf_write_data !== 32'd0) begin
      errors++;
      $display("FAIL arst_rf got we=%b r%0d=%h want 0 0 0", bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data);
    end
    checks++;
    if (bus.busy_mask !== 32'd0 || bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL arst_busy got busy=%h ready=%b want 0 1", bus.busy_mask, bus.load_ready);
    end
    model_reset();
    set_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_we !== 1'b0 || act_busy !== 32'd0) begin
        errors++; $display("FAIL arst_post c%0d got we=%b busy=%h want 0 0", i, act_we, act_busy);
      end
    end
  endtask

  task automatic test_random();
    logic load_held;
    set_idle();
    load_held = 1'b0;
    for (int n = 0; n < 400; n++) begin
      // Upstream holds a stalled ALU result and an unaccepted load.
      if (!(in_av && exp_stall)) begin
        in_av    = ($urandom_range(0, 99) < 60);
        in_ad    = 5'($urandom_range(0, 7));
        in_adata = $urandom;
      end
      if (!load_held) begin
        in_lv    = ($urandom_range(0, 99) < 50);
        in_ld    = 5'($urandom_range(0, 7));
        in_ldata = $urandom;
      end
      tick();
      load_held = in_lv && !exp_ready;
      checks++;
      if (act_stall !== exp_stall || act_ready !== exp_ready || act_busy !== exp_busy) begin
        errors++;
        $display("FAIL rand_comb n%0d got stall=%b ready=%b busy=%h want %b %b %h",
                 n, act_stall, act_ready, act_busy, exp_stall, exp_ready, exp_busy);
      end
      checks++;
      if (act_we !== exp_we || (exp_we && (act_reg !== exp_reg || act_data !== exp_data))) begin
        errors++;
        $display("FAIL rand_write n%0d got we=%b r%0d=%h want we=%b r%0d=%h",
                 n, act_we, act_reg, act_data, exp_we, exp_reg, exp_data);
      end
    end
    set_idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst_n = 1'b1;
    set_idle();
    bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
    bus.load_valid = 1'b0; bus.load_dest = '0; bus.load_data = '0;
    model_reset();
    exp_stall = 1'b0;
    exp_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_alu_only();
    test_bypass();
    test_collision();
    test_fill();
    test_waw();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
